// File: rtl/wf_window_ctrl.sv
// Per-channel display-window editor driven by push buttons: pan, grow/shrink, channel select.
// Define WF_WINDOW_AUTO_REPEAT_EN to make a held pan/grow/shrink button auto-repeat.
module wf_window_ctrl #(
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned X_MAX         = 639,
  parameter int unsigned Y_MAX         = 479,
  parameter int unsigned STEP          = 8,
  parameter int unsigned MIN_W         = 64,
  parameter int unsigned MIN_H         = 32,
  parameter int unsigned DEF_SX        = 160,
  parameter int unsigned DEF_EX        = 479,
  parameter int unsigned DEF_SY        = 120,
  parameter int unsigned DEF_EY        = 359,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4,
  localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_grow,
  input  logic                        btn_shrink,
  input  logic                        btn_ch,
  output logic [NUM_CH*COORD_W-1:0]   start_x,
  output logic [NUM_CH*COORD_W-1:0]   end_x,
  output logic [NUM_CH*COORD_W-1:0]   start_y,
  output logic [NUM_CH*COORD_W-1:0]   end_y,
  output logic [SEL_W-1:0]            sel_ch,
  output logic                        changed
);

  localparam int unsigned CW1 = COORD_W + 1;
  localparam int unsigned NB  = 7;
  localparam int unsigned B_CH = 0, B_LEFT = 1, B_RIGHT = 2, B_UP = 3;
  localparam int unsigned B_DOWN = 4, B_GROW = 5, B_SHRINK = 6;

  // Encoding is button index + 1 so a held-button index maps straight onto its action.
  typedef enum logic [2:0] {
    ACT_NONE, ACT_CH, ACT_LEFT, ACT_RIGHT, ACT_UP, ACT_DOWN, ACT_GROW, ACT_SHRINK
  } act_e;

  if (NUM_CH < 1 || NUM_CH > 8 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("wf_window_ctrl: unsupported parameter set");
  end

  logic [NB-1:0]    btn, btn_q, edges;
  act_e             act;
  int unsigned      base;
  logic [SEL_W-1:0] sel_n;
  logic [CW1-1:0]   sx, ex, sy, ey;
  logic [CW1-1:0]   sx_n, ex_n, sy_n, ey_n;
  logic             changed_n;

  assign btn   = {btn_shrink, btn_grow, btn_down, btn_up, btn_right, btn_left, btn_ch};
  assign edges = btn & ~btn_q;

  // Largest move toward a bound that does not cross it.
  function automatic logic [CW1-1:0] room_step(input logic [CW1-1:0] room);
    return (room < CW1'(STEP)) ? room : CW1'(STEP);
  endfunction

`ifdef WF_WINDOW_AUTO_REPEAT_EN
  localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);

  logic [2:0]       hold_idx, hold_q;
  logic             armed_q, rpt_fire;
  logic [CNT_W-1:0] cnt_q;

  // Highest-priority held button among pan/grow/shrink; 0 means none held.
  always_comb begin
    hold_idx = 3'd0;
    for (int i = 6; i >= 1; i--) begin
      if (btn[i]) hold_idx = 3'(i);
    end
  end

  assign rpt_fire = armed_q && (hold_idx != 3'd0) && (hold_idx == hold_q) &&
                    (cnt_q == CNT_W'(REPEAT_DELAY - 1));

  // A hold only arms when it began with a real press, so a button held through reset stays inert.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= 3'd0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hold_q <= hold_idx;
      if ((hold_idx == 3'd0) || (hold_idx != hold_q)) begin
        cnt_q   <= '0;
        armed_q <= (hold_idx != 3'd0) && edges[hold_idx];
      end else if (rpt_fire) begin
        cnt_q <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else if (cnt_q != CNT_W'(REPEAT_DELAY - 1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`endif

  // One action per cycle, fixed priority; losing edges are dropped.
  always_comb begin
    act = ACT_NONE;
    if      (edges[B_CH])     act = ACT_CH;
    else if (edges[B_LEFT])   act = ACT_LEFT;
    else if (edges[B_RIGHT])  act = ACT_RIGHT;
    else if (edges[B_UP])     act = ACT_UP;
    else if (edges[B_DOWN])   act = ACT_DOWN;
    else if (edges[B_GROW])   act = ACT_GROW;
    else if (edges[B_SHRINK]) act = ACT_SHRINK;
`ifdef WF_WINDOW_AUTO_REPEAT_EN
    else if (rpt_fire)        act = act_e'(hold_q + 3'd1);
`endif
  end

  always_comb begin
    base      = 32'(sel_ch) * COORD_W;
    sx        = CW1'(start_x[base +: COORD_W]);
    ex        = CW1'(end_x[base +: COORD_W]);
    sy        = CW1'(start_y[base +: COORD_W]);
    ey        = CW1'(end_y[base +: COORD_W]);
    sx_n      = sx;
    ex_n      = ex;
    sy_n      = sy;
    ey_n      = ey;
    sel_n     = sel_ch;
    changed_n = 1'b0;
    case (act)
      ACT_CH:    sel_n = (sel_ch == SEL_W'(NUM_CH - 1)) ? '0 : sel_ch + SEL_W'(1);
      ACT_LEFT:  begin
        sx_n = sx - room_step(sx);
        ex_n = ex - room_step(sx);
      end
      ACT_RIGHT: begin
        sx_n = sx + room_step(CW1'(X_MAX) - ex);
        ex_n = ex + room_step(CW1'(X_MAX) - ex);
      end
      ACT_UP:    begin
        sy_n = sy - room_step(sy);
        ey_n = ey - room_step(sy);
      end
      ACT_DOWN:  begin
        sy_n = sy + room_step(CW1'(Y_MAX) - ey);
        ey_n = ey + room_step(CW1'(Y_MAX) - ey);
      end
      ACT_GROW:  begin
        sx_n = sx - room_step(sx);
        ex_n = ex + room_step(CW1'(X_MAX) - ex);
        sy_n = sy - room_step(sy);
        ey_n = ey + room_step(CW1'(Y_MAX) - ey);
      end
      ACT_SHRINK: begin
        if (ex - sx + CW1'(1) >= CW1'(MIN_W + 2 * STEP)) begin
          sx_n = sx + CW1'(STEP);
          ex_n = ex - CW1'(STEP);
        end
        if (ey - sy + CW1'(1) >= CW1'(MIN_H + 2 * STEP)) begin
          sy_n = sy + CW1'(STEP);
          ey_n = ey - CW1'(STEP);
        end
      end
      default: ;
    endcase
    changed_n = (sx_n != sx) || (ex_n != ex) || (sy_n != sy) || (ey_n != ey);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q   <= '1;
      sel_ch  <= '0;
      changed <= 1'b0;
      start_x <= {NUM_CH{COORD_W'(DEF_SX)}};
      end_x   <= {NUM_CH{COORD_W'(DEF_EX)}};
      start_y <= {NUM_CH{COORD_W'(DEF_SY)}};
      end_y   <= {NUM_CH{COORD_W'(DEF_EY)}};
    end else begin
      btn_q   <= btn;
      sel_ch  <= sel_n;
      changed <= changed_n;
      start_x[base +: COORD_W] <= COORD_W'(sx_n);
      end_x[base +: COORD_W]   <= COORD_W'(ex_n);
      start_y[base +: COORD_W] <= COORD_W'(sy_n);
      end_y[base +: COORD_W]   <= COORD_W'(ey_n);
    end
  end

endmodule

// File: tb/tb_wf_window_ctrl.sv
// Self-checking bench for wf_window_ctrl (default build): directed scenarios plus
// randomized button traffic compared every cycle against an integer window model.
module tb_wf_window_ctrl;

  localparam int COORD_W = 10;
  localparam int NUM_CH  = 2;
  localparam int X_MAX   = 639;
  localparam int Y_MAX   = 479;
  localparam int STEP    = 8;
  localparam int MIN_W   = 64;
  localparam int MIN_H   = 32;
  localparam int DEF_SX  = 160, DEF_EX = 479, DEF_SY = 120, DEF_EY = 359;

  // Button vector layout: {shrink, grow, down, up, right, left, ch}
  localparam logic [6:0] K_CH = 7'h01, K_LEFT = 7'h02, K_RIGHT = 7'h04, K_UP = 7'h08;
  localparam logic [6:0] K_DOWN = 7'h10, K_GROW = 7'h20, K_SHRINK = 7'h40;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_left, btn_right, btn_up, btn_down, btn_grow, btn_shrink, btn_ch;
  logic [NUM_CH*COORD_W-1:0] start_x, end_x, start_y, end_y;
  logic sel_ch;
  logic changed;

  always #5 clk = ~clk;

  wf_window_ctrl #(
    .COORD_W(COORD_W), .NUM_CH(NUM_CH), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP),
    .MIN_W(MIN_W), .MIN_H(MIN_H), .DEF_SX(DEF_SX), .DEF_EX(DEF_EX),
    .DEF_SY(DEF_SY), .DEF_EY(DEF_EY), .REPEAT_DELAY(16), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_grow(btn_grow), .btn_shrink(btn_shrink), .btn_ch(btn_ch),
    .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
    .sel_ch(sel_ch), .changed(changed)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_sx[NUM_CH], m_ex[NUM_CH], m_sy[NUM_CH], m_ey[NUM_CH];
  int m_sel;
  int m_chg;
  logic [6:0] m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Window rules applied directly to integer coordinates of the selected channel.
  task automatic model_step(input logic r, input logic [6:0] b);
    logic [6:0] e;
    int c, s, o_sx, o_ex, o_sy, o_ey;
    if (!r) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_sx[k] = DEF_SX; m_ex[k] = DEF_EX; m_sy[k] = DEF_SY; m_ey[k] = DEF_EY;
      end
      m_sel = 0; m_chg = 0; m_prev = '1;
      return;
    end
    e = b & ~m_prev;
    m_prev = b;
    c = m_sel;
    o_sx = m_sx[c]; o_ex = m_ex[c]; o_sy = m_sy[c]; o_ey = m_ey[c];
    if (e[0]) m_sel = (m_sel + 1) % NUM_CH;
    else if (e[1]) begin s = imin(STEP, m_sx[c]); m_sx[c] -= s; m_ex[c] -= s; end
    else if (e[2]) begin s = imin(STEP, X_MAX - m_ex[c]); m_sx[c] += s; m_ex[c] += s; end
    else if (e[3]) begin s = imin(STEP, m_sy[c]); m_sy[c] -= s; m_ey[c] -= s; end
    else if (e[4]) begin s = imin(STEP, Y_MAX - m_ey[c]); m_sy[c] += s; m_ey[c] += s; end
    else if (e[5]) begin
      m_sx[c] -= imin(STEP, m_sx[c]); m_ex[c] += imin(STEP, X_MAX - m_ex[c]);
      m_sy[c] -= imin(STEP, m_sy[c]); m_ey[c] += imin(STEP, Y_MAX - m_ey[c]);
    end else if (e[6]) begin
      if (m_ex[c] - m_sx[c] + 1 - 2 * STEP >= MIN_W) begin m_sx[c] += STEP; m_ex[c] -= STEP; end
      if (m_ey[c] - m_sy[c] + 1 - 2 * STEP >= MIN_H) begin m_sy[c] += STEP; m_ey[c] -= STEP; end
    end
    m_chg = (o_sx != m_sx[c] || o_ex != m_ex[c] || o_sy != m_sy[c] || o_ey != m_ey[c]) ? 1 : 0;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("ch%0d start_x", k), 32'(start_x[k*COORD_W +: COORD_W]), m_sx[k]);
      check($sformatf("ch%0d end_x", k),   32'(end_x[k*COORD_W +: COORD_W]),   m_ex[k]);
      check($sformatf("ch%0d start_y", k), 32'(start_y[k*COORD_W +: COORD_W]), m_sy[k]);
      check($sformatf("ch%0d end_y", k),   32'(end_y[k*COORD_W +: COORD_W]),   m_ey[k]);
    end
    check("sel_ch", 32'(sel_ch), m_sel);
    check("changed", 32'(changed), m_chg);
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, sample 1 ns later.
  task automatic tick(input logic r, input logic [6:0] b);
    @(negedge clk);
    rst_n = r;
    {btn_shrink, btn_grow, btn_down, btn_up, btn_right, btn_left, btn_ch} = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [6:0] b);
    tick(1'b1, b);
    tick(1'b1, 7'h00);
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b0, 7'h00);
    tick(1'b1, 7'h00);
  endtask

  logic [6:0] rb;
  logic       rr;

  initial begin
    rst_n = 1'b0;
    {btn_shrink, btn_grow, btn_down, btn_up, btn_right, btn_left, btn_ch} = 7'h00;

    // Reset defaults
    do_reset();
    check("rst ch0 sx", 32'(start_x[9:0]), 160);
    check("rst ch1 ey", 32'(end_y[19:10]), 359);
    check("rst sel", 32'(sel_ch), 0);
    check("rst changed", 32'(changed), 0);

    // Held right: one step only
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, K_RIGHT);
      if (i == 0) begin
        check("hold first sx", 32'(start_x[9:0]), 168);
        check("hold first ex", 32'(end_x[9:0]), 487);
        check("hold first changed", 32'(changed), 1);
      end
    end
    check("hold end sx", 32'(start_x[9:0]), 168);
    check("hold end changed", 32'(changed), 0);
    tick(1'b1, 7'h00);

    // Right presses saturate at X_MAX, then clamp as no-ops
    repeat (25) press(K_RIGHT);
    check("sat ex", 32'(end_x[9:0]), 639);
    check("sat sx", 32'(start_x[9:0]), 320);
    tick(1'b1, K_RIGHT);
    check("sat clamp changed", 32'(changed), 0);
    tick(1'b1, 7'h00);

    // Shrink down to minimum size on both axes
    do_reset();
    repeat (20) press(K_SHRINK);
    check("shrink sx", 32'(start_x[9:0]), 288);
    check("shrink ex", 32'(end_x[9:0]), 351);
    check("shrink sy", 32'(start_y[9:0]), 224);
    check("shrink ey", 32'(end_y[9:0]), 255);

    // Channel select, pan ch1, simultaneous up+down
    do_reset();
    press(K_CH);
    check("sel after ch", 32'(sel_ch), 1);
    press(K_LEFT);
    check("ch1 sx left", 32'(start_x[19:10]), 152);
    check("ch1 ex left", 32'(end_x[19:10]), 471);
    check("ch0 sx untouched", 32'(start_x[9:0]), 160);
    tick(1'b1, K_UP | K_DOWN);
    check("ch1 sy up wins", 32'(start_y[19:10]), 112);
    check("ch1 ey up wins", 32'(end_y[19:10]), 351);
    tick(1'b1, 7'h00);
    press(K_CH);
    check("sel wraps", 32'(sel_ch), 0);

    // Button held through reset stays inert until re-pressed
    tick(1'b1, K_RIGHT);
    repeat (3) tick(1'b0, K_RIGHT);
    repeat (5) tick(1'b1, K_RIGHT);
    check("held thru rst sx", 32'(start_x[9:0]), 160);
    tick(1'b1, 7'h00);
    tick(1'b1, K_RIGHT);
    check("repress sx", 32'(start_x[9:0]), 168);
    tick(1'b1, 7'h00);

    // Randomized button traffic with occasional resets
    rb = 7'h00;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 7; k++) begin
        if ($urandom_range(0, 5) == 0) rb[k] = ~rb[k];
      end
      rr = ($urandom_range(0, 399) != 0);
      tick(rr, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wf_window_ctrl.md
Name: wf_window_ctrl

Overview:
Parametrised successor to the button-driven waveform window-limit block. Holds NUM_CH independent display windows (start_x/end_x/start_y/end_y), one per waveform channel, and edits the selected one from push buttons. Supports pan, grow/shrink with clamping, and channel select. Sits between the board button inputs and the waveform display/VGA pixel logic.

Parameters:
COORD_W, 10, coordinate width in bits
NUM_CH, 2, number of windows/channels (1..8)
X_MAX, 639, largest legal x coordinate
Y_MAX, 479, largest legal y coordinate
STEP, 8, pixels moved per action
MIN_W, 64, minimum window width (end_x-start_x+1)
MIN_H, 32, minimum window height
DEF_SX/DEF_EX/DEF_SY/DEF_EY, 160/479/120/359, reset window for every channel
REPEAT_DELAY, 16, hold cycles before first auto-repeat (optional feature only)
REPEAT_PERIOD, 4, cycles between auto-repeats (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_left/btn_right/btn_up/btn_down  in  1 each  pan the selected window
btn_grow/btn_shrink  in  1 each  resize the selected window symmetrically
btn_ch  in  1  select the next channel
start_x/end_x/start_y/end_y  out  NUM_CH*COORD_W each  flattened windows, ch0 in LSBs
sel_ch  out  clog2(NUM_CH) (min 1)  currently selected channel
changed  out  1  one-cycle pulse: a coordinate changed

Behaviour:
- Reset when rst_n=0 at a clk edge. Reset overrides all other activity. All channels load DEF_*. sel_ch=0, changed=0.
- Each button is registered as btn_q. Reset loads btn_q=1, so a button held through reset release does not act until it is released and pressed again.
- Edge: btn & ~btn_q. If a button is low at edge N-1 and high at edge N, the registers update at edge N. The new value is visible in the cycle after edge N (1-cycle latency).
- Only one action per cycle. Priority: ch > left > right > up > down > grow > shrink. Lower-priority edges in the same cycle are dropped, not queued.
- btn_ch: sel_ch = (sel_ch+1) mod NUM_CH. It wraps from NUM_CH-1 to 0. changed stays 0.
- Pan actions apply only to the selected channel and keep the window size fixed:
  - left: shift = min(STEP, start_x)
  - right: shift = min(STEP, X_MAX-end_x)
  - up and down: the same rules on the y axis against 0 and Y_MAX.
- grow, per edge independently: start -= min(STEP, start); end += min(STEP, MAX-end).
- shrink, per axis: apply start+=STEP and end-=STEP only if the resulting size is >= MIN_W (x) or MIN_H (y). Otherwise that axis is unchanged.
- Arithmetic uses COORD_W+1 bits. A register never wraps below 0 or above MAX.
- changed=1 for exactly one cycle, the cycle after an action that altered at least one coordinate. A fully clamped no-op gives changed=0.
- Invariant at all times: start<=end, end<=MAX, size>=min(MIN, default size).

Optional Feature:
Macro WF_WINDOW_AUTO_REPEAT_EN.
- Defined: a hold counter tracks the highest-priority held button among pan/grow/shrink (btn_ch is excluded).
  - After the edge action, the held button repeats the action at REPEAT_DELAY cycles after the edge, then every REPEAT_PERIOD cycles.
  - The counter clears on reset, on release, or when the highest-priority held button changes.
- Undefined: no counter logic. Only edges act.

Test Plan:
1. Reset, no buttons -> both channels show (160,479,120,359); sel_ch=0; changed=0.
2. btn_right high for 10 cycles, no macro -> ch0 start_x=168, end_x=487 one cycle after the first edge. changed pulses once; no further steps.
3. 25 separate btn_right presses -> ch0 end_x saturates at 639, start_x=320. Later presses leave the values unchanged with changed=0.
4. 20 btn_shrink presses on defaults:
   - x narrows 16 per press to width 64 after 16 presses, then holds (start_x=288, end_x=351).
   - y reaches height 32 after 13 presses (start_y=224, end_y=255), then holds.
5. btn_ch, then btn_left -> sel_ch=1; ch1 start_x=152, end_x=471; ch0 unchanged. btn_up and btn_down rising in the same cycle -> only up applied (ch1 start_y=112).
6. Hold btn_right across rst_n low 3 cycles then high -> no movement until release and re-press. With the macro (delay 16, period 4), hold btn_down -> steps at edge, +16, +20, +24 cycles.
